matrix_ls_sequencer: RTL and testbench
======================================

MATRIX_LS_SEQUENCER -- requirements
Module: matrix_ls_sequencer

Interface
REQ-001 SHALL have parameters: ROWS, 4, matrix rows per transfer; ROW_W, 64, bits per row (4 x fp16); ADDR_W, 32, byte-address width; MREG_W, 4, matrix-register index width.
REQ-002 SHALL have ports (name direction width meaning):
- CLK in 1 clock.
- RST in 1 synchronous active-high reset.
- req_valid in 1 request from matrix LS FU.
- req_ready out 1 sequencer can accept.
- req_ls in 2 op select: [0] load, [1] store.
- req_rd in MREG_W target/source matrix register.
- req_addr in ADDR_W base address.
- req_stride in ADDR_W row stride, bytes.
- mem_req out 1 memory request.
- mem_wen out 1 request is write.
- mem_addr out ADDR_W row address.
- mem_wdata out ROW_W store data.
- mem_gnt in 1 request accepted.
- mem_rvalid in 1 load data valid.
- mem_rdata in ROW_W load data.
- mrf_ren out 1 matrix RF read.
- mrf_rsel out MREG_W read register.
- mrf_rrow out 2 read row.
- mrf_rdata in ROW_W read data, valid 1 cycle after mrf_ren.
- mrf_wen out 1 matrix RF write.
- mrf_wsel out MREG_W write register.
- mrf_wrow out 2 write row.
- mrf_wdata out ROW_W write data.
- mhit out 1 one-cycle completion pulse to FU done.
- busy out 1 high in every state except IDLE.

Function
REQ-003 SHALL implement FSM states IDLE, RDREG, MEMREQ, WAITRESP, DONE.
REQ-004 SHALL assert req_ready only in IDLE; handshake = req_valid & req_ready; on handshake latch ls, rd, addr, stride; clear row counter to 0.
REQ-005 Load (ls=01): IDLE -> MEMREQ; MEMREQ holds mem_req=1, mem_wen=0, mem_addr stable until mem_gnt, then -> WAITRESP.
REQ-006 In WAITRESP on mem_rvalid, SHALL drive mrf_wen=1, mrf_wsel=rd, mrf_wrow=row, mrf_wdata=mem_rdata that same cycle; if row==ROWS-1 -> DONE else row+1 and -> MEMREQ.
REQ-007 Store (ls=10): IDLE -> RDREG; RDREG drives mrf_ren=1, mrf_rsel=rd, mrf_rrow=row for one cycle -> MEMREQ; mrf_rdata captured into mem_wdata register on MEMREQ entry.
REQ-008 Store MEMREQ holds mem_req=1, mem_wen=1, mem_addr, mem_wdata stable until mem_gnt; on gnt, if row==ROWS-1 -> DONE else row+1 and -> RDREG (posted writes, no response).
REQ-009 Row address SHALL be base + row*stride via running accumulator adding stride per row, modulo 2^ADDR_W (wrap-around, no fault); stride 0 legal, all rows same address.
REQ-010 DONE SHALL assert mhit for exactly one cycle then -> IDLE; new request accepted no earlier than the cycle after DONE.
REQ-011 ls=00 or ls=11 SHALL be consumed as no-op: IDLE -> DONE, no mem or mrf activity, mhit pulses.
REQ-012 mem_rvalid outside WAITRESP and mem_gnt outside MEMREQ SHALL be ignored.
REQ-013 req_valid while not IDLE SHALL be ignored (not latched).
REQ-014 Best-case latency: load 2*ROWS+1 cycles handshake-to-mhit with gnt and rvalid each one cycle after entry; store 2*ROWS+1 with immediate gnt.

Reset
REQ-015 RST high at a CLK edge SHALL force IDLE, row=0, all latched fields 0, regardless of state (aborts in-flight transfer; no mhit).
REQ-016 While in reset state all outputs SHALL be 0 except req_ready, which is 1 from the first cycle after RST deasserts.

Configuration
REQ-017 Macro MATRIX_LS_PERF_CNT_EN: when defined, SHALL add outputs ld_count (32, out) and st_count (32, out) counting completed loads/stores (incremented in DONE, wrap at 2^32, cleared by RST); ls no-ops not counted.
REQ-018 Without MATRIX_LS_PERF_CNT_EN the ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-019 Load ls=01, rd=3, addr=0x1000, stride=0x40, gnt/rvalid immediate -> mem_addr 0x1000,0x1040,0x1080,0x10C0; mrf writes reg 3 rows 0-3; one mhit at cycle 9.
REQ-020 Store ls=10, rd=5, addr=0x2000, stride=8, gnt delayed 3 cycles per row -> mem_req/addr/wdata held stable during stall; wdata = mrf reg 5 rows 0-3 in order; one mhit.
REQ-021 Wrap: addr=0xFFFFFFF0, stride=0x10 -> addresses 0xFFFFFFF0, 0x0, 0x10, 0x20.
REQ-022 ls=11 -> req_ready low next cycle, mhit one cycle, no mem_req, no mrf_wen/ren.
REQ-023 RST asserted in WAITRESP of row 2 -> next cycle IDLE, outputs 0, no mhit; late mem_rvalid after reset ignored; perf counters 0 when enabled.
REQ-024 req_valid held high during busy transfer -> only first request executed; second accepted after mhit.

Source files
------------

// File: rtl/matrix_ls_sequencer.sv
// matrix_ls_sequencer
// Sequences matrix-register loads and stores as ROWS row-sized memory
// transfers. Loads issue one read per row and write each returned row into
// the matrix register file. Stores read each row from the register file and
// post one write per row. Row addresses come from a running accumulator that
// starts at the base address and adds the stride for each row, wrapping at
// 2^ADDR_W.
//
// Optional build macro: MATRIX_LS_PERF_CNT_EN adds the ld_count / st_count
// completion counters. Without it those ports and counters do not exist.
module matrix_ls_sequencer #(
  parameter int ROWS   = 4,
  parameter int ROW_W  = 64,
  parameter int ADDR_W = 32,
  parameter int MREG_W = 4
) (
  input  logic              CLK,
  input  logic              RST,
  // request side (matrix LS functional unit)
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_ls,
  input  logic [MREG_W-1:0] req_rd,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ADDR_W-1:0] req_stride,
  // memory side
  output logic              mem_req,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ROW_W-1:0]  mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [ROW_W-1:0]  mem_rdata,
  // matrix register file read port
  output logic              mrf_ren,
  output logic [MREG_W-1:0] mrf_rsel,
  output logic [1:0]        mrf_rrow,
  input  logic [ROW_W-1:0]  mrf_rdata,
  // matrix register file write port
  output logic              mrf_wen,
  output logic [MREG_W-1:0] mrf_wsel,
  output logic [1:0]        mrf_wrow,
  output logic [ROW_W-1:0]  mrf_wdata,
  // status
  output logic              mhit,
  output logic              busy
`ifdef MATRIX_LS_PERF_CNT_EN
  ,
  output logic [31:0]       ld_count,
  output logic [31:0]       st_count
`endif
);

  // Op select encodings; anything else completes as a no-op.
  localparam logic [1:0] LS_LOAD  = 2'b01;
  localparam logic [1:0] LS_STORE = 2'b10;

  // Index of the final row of a transfer (row counter is as wide as the RF row port).
  localparam logic [1:0] LAST_ROW = 2'(ROWS - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RDREG    = 3'd1,
    MEMREQ   = 3'd2,
    WAITRESP = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t state_reg;
  state_t state_next;

  // Fields captured at the request handshake.
  logic [1:0]        ls_reg;
  logic [MREG_W-1:0] rd_reg;
  logic [ADDR_W-1:0] stride_reg;

  // Current row and its byte address (base + row*stride, kept incrementally).
  logic [1:0]        row_reg;
  logic [ADDR_W-1:0] addr_reg;

  // Store data path: the RF returns data in the first MEMREQ cycle after the
  // RDREG read. That cycle forwards mrf_rdata directly and captures it; later
  // stall cycles replay the captured copy so mem_wdata stays stable.
  logic [ROW_W-1:0]  wdata_reg;
  logic              wdata_fresh_reg;

  logic handshake;
  logic is_store;
  logic last_row;
  logic row_advance;

  assign handshake = (state_reg == IDLE) && req_valid && !RST;
  assign is_store  = (ls_reg == LS_STORE);
  assign last_row  = (row_reg == LAST_ROW);

  // A row finishes on a store grant or a load response; step to the next row
  // unless this was the final one.
  assign row_advance = !last_row &&
                       (((state_reg == MEMREQ) && is_store && mem_gnt) ||
                        ((state_reg == WAITRESP) && mem_rvalid));

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state selection.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          case (req_ls)
            LS_LOAD:  state_next = MEMREQ;
            LS_STORE: state_next = RDREG;
            default:  state_next = DONE;
          endcase
        end
      end
      RDREG: begin
        state_next = MEMREQ;
      end
      MEMREQ: begin
        if (mem_gnt) begin
          if (!is_store) begin
            state_next = WAITRESP;
          end else if (last_row) begin
            state_next = DONE;
          end else begin
            state_next = RDREG;
          end
        end
      end
      WAITRESP: begin
        if (mem_rvalid) begin
          state_next = last_row ? DONE : MEMREQ;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request fields, row counter, address accumulator and store-data capture.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ls_reg          <= '0;
      rd_reg          <= '0;
      stride_reg      <= '0;
      row_reg         <= '0;
      addr_reg        <= '0;
      wdata_reg       <= '0;
      wdata_fresh_reg <= 1'b0;
    end else begin
      if (handshake) begin
        ls_reg     <= req_ls;
        rd_reg     <= req_rd;
        stride_reg <= req_stride;
        addr_reg   <= req_addr;
        row_reg    <= '0;
      end else if (row_advance) begin
        row_reg  <= row_reg + 2'd1;
        addr_reg <= addr_reg + stride_reg;
      end

      if (state_reg == RDREG) begin
        wdata_fresh_reg <= 1'b1;
      end else if ((state_reg == MEMREQ) && wdata_fresh_reg) begin
        wdata_reg       <= mrf_rdata;
        wdata_fresh_reg <= 1'b0;
      end
    end
  end

  // Output decode; everything idles at zero outside the state that owns it.
  always_comb begin
    req_ready = 1'b0;
    busy      = 1'b0;
    mem_req   = 1'b0;
    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mrf_ren   = 1'b0;
    mrf_rsel  = '0;
    mrf_rrow  = '0;
    mrf_wen   = 1'b0;
    mrf_wsel  = '0;
    mrf_wrow  = '0;
    mrf_wdata = '0;
    mhit      = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = !RST;
      end
      RDREG: begin
        busy     = 1'b1;
        mrf_ren  = 1'b1;
        mrf_rsel = rd_reg;
        mrf_rrow = row_reg;
      end
      MEMREQ: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_wen  = is_store;
        mem_addr = addr_reg;
        if (is_store) begin
          mem_wdata = wdata_fresh_reg ? mrf_rdata : wdata_reg;
        end
      end
      WAITRESP: begin
        busy = 1'b1;
        if (mem_rvalid) begin
          mrf_wen   = 1'b1;
          mrf_wsel  = rd_reg;
          mrf_wrow  = row_reg;
          mrf_wdata = mem_rdata;
        end
      end
      DONE: begin
        busy = 1'b1;
        mhit = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

`ifdef MATRIX_LS_PERF_CNT_EN
  logic [31:0] ld_count_reg;
  logic [31:0] st_count_reg;

  // Completed load/store counters, bumped once per transfer in DONE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ld_count_reg <= '0;
      st_count_reg <= '0;
    end else if (state_reg == DONE) begin
      if (ls_reg == LS_LOAD) begin
        ld_count_reg <= ld_count_reg + 32'd1;
      end
      if (ls_reg == LS_STORE) begin
        st_count_reg <= st_count_reg + 32'd1;
      end
    end
  end

  assign ld_count = ld_count_reg;
  assign st_count = st_count_reg;
`endif

endmodule

// File: tb/tb_matrix_ls_sequencer.sv
// Testbench for matrix_ls_sequencer: directed scenarios plus randomized
// transfers, checked against a transaction-level model (expected row
// addresses, write data and register-file traffic per request).
module tb_matrix_ls_sequencer;

  localparam int ROWS   = 4;
  localparam int ROW_W  = 64;
  localparam int ADDR_W = 32;
  localparam int MREG_W = 4;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [1:0]        req_ls = '0;
  logic [MREG_W-1:0] req_rd = '0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [ADDR_W-1:0] req_stride = '0;
  logic              mem_req;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [ROW_W-1:0]  mem_wdata;
  logic              mem_gnt = 1'b0;
  logic              mem_rvalid = 1'b0;
  logic [ROW_W-1:0]  mem_rdata = '0;
  logic              mrf_ren;
  logic [MREG_W-1:0] mrf_rsel;
  logic [1:0]        mrf_rrow;
  logic [ROW_W-1:0]  mrf_rdata = '0;
  logic              mrf_wen;
  logic [MREG_W-1:0] mrf_wsel;
  logic [1:0]        mrf_wrow;
  logic [ROW_W-1:0]  mrf_wdata;
  logic              mhit;
  logic              busy;
`ifdef MATRIX_LS_PERF_CNT_EN
  logic [31:0]       ld_count;
  logic [31:0]       st_count;
`endif

  matrix_ls_sequencer #(
    .ROWS(ROWS), .ROW_W(ROW_W), .ADDR_W(ADDR_W), .MREG_W(MREG_W)
  ) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_ls(req_ls),
    .req_rd(req_rd), .req_addr(req_addr), .req_stride(req_stride),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata),
    .mrf_ren(mrf_ren), .mrf_rsel(mrf_rsel), .mrf_rrow(mrf_rrow),
    .mrf_rdata(mrf_rdata),
    .mrf_wen(mrf_wen), .mrf_wsel(mrf_wsel), .mrf_wrow(mrf_wrow),
    .mrf_wdata(mrf_wdata),
    .mhit(mhit), .busy(busy)
`ifdef MATRIX_LS_PERF_CNT_EN
    , .ld_count(ld_count), .st_count(st_count)
`endif
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- environment state ----------------
  typedef struct { logic wen; logic [ADDR_W-1:0] addr; logic [ROW_W-1:0] data; } mem_op_t;
  typedef struct { logic [MREG_W-1:0] sel; logic [1:0] row; logic [ROW_W-1:0] data; } rf_wr_t;

  mem_op_t           obs_mem[$];
  rf_wr_t            obs_wr[$];
  logic [ADDR_W-1:0] pend_q[$];
  logic [ROW_W-1:0]  rf [16][4];

  // staged request/reset values, applied at the next falling edge
  logic              want_rst = 1'b1;
  logic              want_valid = 1'b0;
  logic [1:0]        want_ls = '0;
  logic [MREG_W-1:0] want_rd = '0;
  logic [ADDR_W-1:0] want_addr = '0;
  logic [ADDR_W-1:0] want_stride = '0;

  int          gnt_delay = 0;     // <0: random grant with gnt_prob
  int unsigned gnt_prob = 100;
  int unsigned rsp_prob = 100;
  logic        spur_en = 1'b0;
  logic        force_spur = 1'b0;

  logic              rd_pend = 1'b0;
  logic [MREG_W-1:0] rd_sel = '0;
  logic [1:0]        rd_row = '0;
  logic              stall_prev = 1'b0;
  int                stall_cnt = 0;
  logic              snap_wen;
  logic [ADDR_W-1:0] snap_addr;
  logic [ROW_W-1:0]  snap_wdata;
  int   cyc = 0, hs_cyc = 0, mhit_cyc = 0;
  int   hs_seen = 0, mhit_seen = 0, ren_cnt = 0;
  logic prev_mhit = 1'b0;
  int   exp_ld = 0, exp_st = 0;

  // Memory returns an address-derived pattern so load data is predictable.
  function automatic logic [ROW_W-1:0] ld_data(input logic [ADDR_W-1:0] a);
    return {a ^ 32'hA5A5_5A5A, a + 32'h1357_9BDF};
  endfunction

  task automatic drive_inputs();
    RST        = want_rst;
    req_valid  = want_valid;
    req_ls     = want_ls;
    req_rd     = want_rd;
    req_addr   = want_addr;
    req_stride = want_stride;
    if (gnt_delay < 0) mem_gnt = ($urandom_range(99) < gnt_prob);
    else               mem_gnt = (stall_cnt >= gnt_delay);
    if (pend_q.size() > 0 && $urandom_range(99) < rsp_prob) begin
      mem_rvalid = 1'b1;
      mem_rdata  = ld_data(pend_q.pop_front());
    end else if (pend_q.size() == 0 && (force_spur || (spur_en && $urandom_range(7) == 0))) begin
      mem_rvalid = 1'b1;
      mem_rdata  = {$urandom, $urandom};
      force_spur = 1'b0;
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = {$urandom, $urandom};
    end
    // register file: data valid only in the cycle after the read request
    if (rd_pend) mrf_rdata = rf[rd_sel][rd_row];
    else         mrf_rdata = {$urandom, $urandom};
    rd_pend = 1'b0;
  endtask

  task automatic sample();
    cyc++;
    if (req_valid && req_ready && !RST) begin
      hs_seen++;
      hs_cyc = cyc;
    end
    check_eq("busy_vs_ready", busy, !req_ready && !(RST && !busy));
    if (stall_prev) begin
      check_eq("stall_req", mem_req, 1);
      check_eq("stall_wen", mem_wen, snap_wen);
      check_eq("stall_addr", mem_addr, snap_addr);
      check_eq("stall_wdata", mem_wdata, snap_wdata);
    end
    stall_prev = mem_req && !mem_gnt && !RST;
    stall_cnt  = stall_prev ? stall_cnt + 1 : 0;
    snap_wen = mem_wen; snap_addr = mem_addr; snap_wdata = mem_wdata;
    if (mem_req && mem_gnt && !RST) begin
      obs_mem.push_back('{mem_wen, mem_addr, mem_wdata});
      if (!mem_wen) pend_q.push_back(mem_addr);
    end
    if (mrf_wen && !RST) obs_wr.push_back('{mrf_wsel, mrf_wrow, mrf_wdata});
    if (mrf_ren && !RST) begin
      rd_pend = 1'b1; rd_sel = mrf_rsel; rd_row = mrf_rrow; ren_cnt++;
    end
    if (mhit) begin
      check_eq("mhit_width", prev_mhit, 0);
      check_eq("ready_in_done", req_ready, 0);
      mhit_seen++;
      mhit_cyc = cyc;
    end
    prev_mhit = mhit;
  endtask

  task automatic tick();
    @(negedge CLK);
    drive_inputs();
    #1;
    sample();
  endtask

  // Run one request to completion and compare against the expected transfer.
  task automatic run_txn(input logic [1:0] ls, input logic [MREG_W-1:0] rd,
                         input logic [ADDR_W-1:0] addr, input logic [ADDR_W-1:0] stride,
                         input logic best, input logic keep,
                         input logic [1:0] nls, input logic [MREG_W-1:0] nrd,
                         input logic [ADDR_W-1:0] naddr, input logic [ADDR_W-1:0] nstride);
    mem_op_t           exp_mem[$];
    rf_wr_t            exp_wr[$];
    logic [ADDR_W-1:0] a;
    logic              applied;
    int                exp_ren;
    obs_mem.delete(); obs_wr.delete();
    hs_seen = 0; mhit_seen = 0; ren_cnt = 0; applied = 1'b0;
    a = addr;
    exp_ren = 0;
    for (int r = 0; r < ROWS; r++) begin
      if (ls == 2'b01) begin
        exp_mem.push_back('{1'b0, a, '0});
        exp_wr.push_back('{rd, 2'(r), ld_data(a)});
      end else if (ls == 2'b10) begin
        exp_mem.push_back('{1'b1, a, rf[rd][r]});
        exp_ren++;
      end
      a = a + stride;
    end
    want_valid = 1'b1; want_ls = ls; want_rd = rd; want_addr = addr; want_stride = stride;
    for (int i = 0; i < 600 && mhit_seen == 0; i++) begin
      tick();
      if (hs_seen != 0 && !applied) begin
        applied = 1'b1;
        if (keep) begin
          want_ls = nls; want_rd = nrd; want_addr = naddr; want_stride = nstride;
        end else begin
          want_valid = 1'b0;
        end
      end
    end
    check_eq("mhit_seen", mhit_seen, 1);
    check_eq("handshakes", hs_seen, 1);
    check_eq("mem_count", obs_mem.size(), exp_mem.size());
    for (int i = 0; i < exp_mem.size() && i < obs_mem.size(); i++) begin
      check_eq("mem_wen", obs_mem[i].wen, exp_mem[i].wen);
      check_eq("mem_addr", obs_mem[i].addr, exp_mem[i].addr);
      if (exp_mem[i].wen) check_eq("mem_wdata", obs_mem[i].data, exp_mem[i].data);
    end
    check_eq("mrf_wr_count", obs_wr.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++) begin
      check_eq("mrf_wsel", obs_wr[i].sel, exp_wr[i].sel);
      check_eq("mrf_wrow", obs_wr[i].row, exp_wr[i].row);
      check_eq("mrf_wdata", obs_wr[i].data, exp_wr[i].data);
    end
    check_eq("mrf_ren_count", ren_cnt, exp_ren);
    if (best) check_eq("latency", mhit_cyc - hs_cyc, (ls == 2'b01 || ls == 2'b10) ? 2*ROWS+1 : 1);
    if (ls == 2'b01) exp_ld++;
    if (ls == 2'b10) exp_st++;
`ifdef MATRIX_LS_PERF_CNT_EN
    tick();
    check_eq("ld_count", ld_count, exp_ld);
    check_eq("st_count", st_count, exp_st);
`endif
    $display("[TB] txn ls=%b rd=%0d addr=%h stride=%h latency=%0d", ls, rd, addr, stride, mhit_cyc - hs_cyc);
  endtask

  initial begin
    for (int s = 0; s < 16; s++)
      for (int r = 0; r < 4; r++) rf[s][r] = {$urandom, $urandom};

    // reset: everything low, then ready from the first cycle after release
    want_rst = 1'b1;
    repeat (2) tick();
    check_eq("rst_ready", req_ready, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_mem_req", mem_req, 0);
    check_eq("rst_mhit", mhit, 0);
    check_eq("rst_mrf_wen", mrf_wen, 0);
    want_rst = 1'b0;
    tick();
    check_eq("ready_after_rst", req_ready, 1);
    check_eq("busy_after_rst", busy, 0);
`ifdef MATRIX_LS_PERF_CNT_EN
    check_eq("ld_count_rst", ld_count, 0);
`endif

    // directed: best-case load, stalled store, wrapping addresses, best store
    gnt_delay = 0; rsp_prob = 100; spur_en = 1'b0;
    run_txn(2'b01, 4'd3, 32'h1000, 32'h40, 1'b1, 1'b0, '0, '0, '0, '0);
    gnt_delay = 3;
    run_txn(2'b10, 4'd5, 32'h2000, 32'h8, 1'b0, 1'b0, '0, '0, '0, '0);
    gnt_delay = 0;
    run_txn(2'b01, 4'd7, 32'hFFFF_FFF0, 32'h10, 1'b1, 1'b0, '0, '0, '0, '0);
    run_txn(2'b10, 4'd9, 32'hFFFF_FFE0, 32'h0, 1'b1, 1'b0, '0, '0, '0, '0);
    run_txn(2'b11, 4'd1, 32'h3000, 32'h4, 1'b1, 1'b0, '0, '0, '0, '0);
    run_txn(2'b00, 4'd2, 32'h3000, 32'h4, 1'b1, 1'b0, '0, '0, '0, '0);

    // request held valid across a busy transfer: only the held request follows
    run_txn(2'b01, 4'd4, 32'h4000, 32'h20, 1'b1, 1'b1, 2'b10, 4'd6, 32'h5000, 32'h100);
    run_txn(2'b10, 4'd6, 32'h5000, 32'h100, 1'b1, 1'b0, '0, '0, '0, '0);

    // reset while waiting for the row-2 response of a load
    obs_mem.delete(); obs_wr.delete(); mhit_seen = 0;
    want_valid = 1'b1; want_ls = 2'b01; want_rd = 4'd8; want_addr = 32'h6000; want_stride = 32'h10;
    for (int i = 0; i < 100 && !(obs_wr.size() == 2 && pend_q.size() == 1); i++) begin
      tick();
      if (req_ready == 1'b0) want_valid = 1'b0;
    end
    check_eq("abort_reached", obs_wr.size(), 2);
    want_valid = 1'b0; rsp_prob = 0; want_rst = 1'b1;
    tick();
    want_rst = 1'b0; pend_q.delete(); force_spur = 1'b1;
    tick();
    check_eq("abort_ready", req_ready, 1);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_mem_req", mem_req, 0);
    check_eq("abort_mem_addr", mem_addr, 0);
    check_eq("abort_late_rvalid_wen", mrf_wen, 0);
    check_eq("abort_mrf_wdata", mrf_wdata, 0);
    repeat (3) tick();
    check_eq("abort_no_mhit", mhit_seen, 0);
    check_eq("abort_no_extra_wr", obs_wr.size(), 2);
    exp_ld = 0; exp_st = 0;
`ifdef MATRIX_LS_PERF_CNT_EN
    check_eq("abort_ld_count", ld_count, 0);
    check_eq("abort_st_count", st_count, 0);
`endif
    $display("[TB] txn reset abort during load row 2");

    // randomized traffic with random grants, response latency and stray rvalids
    gnt_delay = -1; gnt_prob = 60; rsp_prob = 50; spur_en = 1'b1;
    for (int t = 0; t < 40; t++) begin
      logic [1:0]        ls;
      logic [ADDR_W-1:0] stride;
      int unsigned       pick;
      pick = $urandom_range(9);
      ls = (pick < 4) ? 2'b01 : (pick < 8) ? 2'b10 : (pick == 8) ? 2'b00 : 2'b11;
      stride = ($urandom_range(3) == 0) ? 32'h0 : $urandom;
      run_txn(ls, 4'($urandom_range(15)), $urandom, stride, 1'b0, 1'b0, '0, '0, '0, '0);
      repeat ($urandom_range(2)) tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
